// File: rtl/bus_err_drain.sv
// Drains the bus error FIFO into a one-entry record register, counts errors
// and coalesces the interrupt by record count, timeout or overflow.
module bus_err_drain #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned ErrBits       = 3,
  parameter int unsigned SeqWidth      = 8,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned IrqThresh     = 4,
  parameter int unsigned IrqTimeout    = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     err_irq_i,
  output logic                     err_fifo_pop_o,
  input  logic [ErrBits-1:0]       err_code_i,
  input  logic [AddrWidth-1:0]     err_addr_i,
  input  logic [MetaDataWidth-1:0] err_meta_i,
  input  logic                     err_fifo_overflow_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [ErrBits-1:0]       rec_code_o,
  output logic [AddrWidth-1:0]     rec_addr_o,
  output logic [MetaDataWidth-1:0] rec_meta_o,
  output logic [SeqWidth-1:0]      rec_seq_o,
  output logic [CntWidth-1:0]      err_count_o,
  output logic                     overflow_o,
  output logic                     irq_o,
  input  logic                     irq_ack_i,
  input  logic                     clear_i
);

  localparam int unsigned PendW = $clog2(IrqThresh + 1);
  localparam int unsigned TimW  = $clog2(IrqTimeout) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FIRE
  } state_e;

  state_e               state_q;
  logic [PendW-1:0]     pend_q;
  logic [PendW-1:0]     pend_inc;
  logic [TimW-1:0]      timer_q;
  logic [SeqWidth-1:0]  seq_q;
  logic [SeqWidth-1:0]  seq_base;
  logic [CntWidth-1:0]  cnt_base;
  logic                 load;
  logic                 fire;

  // Gated by rst_ni so no pop escapes while reset is held.
  assign load = rst_ni & enable_i & err_irq_i
              & (~rec_valid_o | rec_ready_i);
  assign err_fifo_pop_o = load;

  assign seq_base = clear_i ? '0 : seq_q;
  assign cnt_base = clear_i ? '0 : err_count_o;

  assign pend_inc = (pend_q == PendW'(IrqThresh))
                  ? pend_q : pend_q + PendW'(1);

  assign fire = (pend_q >= PendW'(IrqThresh))
              | (timer_q == TimW'(IrqTimeout - 1))
              | overflow_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_valid_o <= 1'b0;
      rec_code_o  <= '0;
      rec_addr_o  <= '0;
      rec_meta_o  <= '0;
      rec_seq_o   <= '0;
      seq_q       <= '0;
    end else if (load) begin
      rec_valid_o <= 1'b1;
      rec_code_o  <= err_code_i;
      rec_addr_o  <= err_addr_i;
      rec_meta_o  <= err_meta_i;
      rec_seq_o   <= seq_base;
      seq_q       <= seq_base + SeqWidth'(1);
    end else begin
      if (rec_ready_i) rec_valid_o <= 1'b0;
      seq_q <= seq_base;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_o <= '0;
      overflow_o  <= 1'b0;
    end else begin
      if (load && (cnt_base != '1)) begin
        err_count_o <= cnt_base + CntWidth'(1);
      end else begin
        err_count_o <= cnt_base;
      end
      if (err_fifo_overflow_i) begin
        overflow_o <= 1'b1;
      end else if (clear_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      timer_q <= '0;
      irq_o   <= 1'b0;
    end else if (irq_ack_i) begin
      irq_o   <= 1'b0;
      timer_q <= '0;
      pend_q  <= load ? PendW'(1) : '0;
      state_q <= load ? ACCUM : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            pend_q  <= PendW'(1);
            timer_q <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          timer_q <= timer_q + TimW'(1);
          if (load) pend_q <= pend_inc;
          if (fire) begin
            state_q <= FIRE;
            irq_o   <= 1'b1;
          end
        end
        FIRE: begin
          if (load) pend_q <= pend_inc;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
